xs3_to_bin_seq: RTL and testbench
=================================

Name: xs3_to_bin_seq

Overview:
Serial excess-3 (XS-3) to binary decoder, the receiving end of the team's binary-to-XS-3 converters. It accepts XS-3 digits most-significant first over a valid/ready handshake and accumulates them into a binary value. It presents the result with an error flag on a second valid/ready handshake. It sits between the XS-3 display/encode path and binary datapath consumers.

Parameters:
NDIG, 3, maximum digits per number (1..4)
OUT_W, 10, binary result width; must satisfy 10^NDIG-1 < 2^OUT_W

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_digit/in_last valid
in_ready  output  1  decoder can accept a digit
in_digit  input  4  XS-3 coded digit (0011..1100 legal)
in_last  input  1  final digit of current number
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_bin  output  OUT_W  decoded binary value
out_err  output  1  illegal code or digit-count overflow in this number

Behaviour:
- Interface decided: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=0 during reset, 1 in first cycle after release. out_valid=0, out_bin=0, out_err=0. Internal acc=0, cnt=0, err=0, state=ACC.
- Digit accept = in_valid & in_ready (rising edge). in_digit/in_last are sampled only on accept.
- FSM states:
  - ACC: in_ready=1, out_valid=0.
    - On accept with in_last=0: stay in ACC.
    - On accept with in_last=1: go to HOLD.
  - HOLD: in_ready=0, out_valid=1.
    - On out_valid & out_ready: go to ACC, clear acc, cnt and err.
- Decode per accepted digit: d = in_digit - 3 (4-bit).
  - Legal: 0011 <= in_digit <= 1100.
  - Illegal code: set err sticky; that digit contributes d=0.
- Accumulate: acc <= acc*10 + d, computed at OUT_W+4 bits and truncated to OUT_W; cnt <= cnt+1.
- Count overflow: an accepted digit with cnt == NDIG already (i.e. the NDIG+1th digit) sets err and leaves acc unchanged. Accepting continues until in_last.
- Result: on the in_last accept, out_bin and out_err are registered. Values are the updated acc and the updated err, including the effect of the last digit itself.
  - If the final err=1, out_bin is forced to 0.
- Latency: out_valid rises on the cycle after the in_last accept.
  - out_bin and out_err stay stable while out_valid=1 and out_ready=0.
- Throughput: a number of N digits takes N accept cycles plus at least 1 HOLD cycle.
  - in_ready is combinationally (state==ACC). It never depends on out_ready, so there is no back-to-back bypass.
- Simultaneous events:
  - out_ready asserted in the same cycle out_valid first rises: the handshake completes that cycle and in_ready=1 the following cycle.
  - out_ready with out_valid=0: ignored.
  - in_valid during HOLD: not accepted; the producer must hold the digit.
- Single-digit number (in_last on first digit): legal; result = d.
- Reset mid-number or mid-HOLD: all state cleared immediately. The partial number is discarded and no out_valid is produced for it.

Optional Feature:
Macro XS3_LEGACY_ZERO_EN.
- Defined: in_digit 0000 is accepted as decimal 0 and does not set err. This is for encoders that emit 0000 for a suppressed leading tens digit.
- Not defined: 0000 is an illegal code like 0000..0010 and 1101..1111, and sets err.

Test Plan:
- Reset then digits 0100,0101,0110 (last on third) -> out_valid one cycle after third accept, out_bin=123, out_err=0.
- Single digit 1100 with in_last -> out_bin=9, out_err=0. Next number 0011 (last) -> out_bin=0, out_err=0.
- Digits 0100,1111,0011 (last) -> out_err=1, out_bin=0. Next number 0110 (last) -> out_bin=3, out_err=0 (sticky cleared).
- NDIG=3, digits 0100,0100,0100,0100 (last on fourth) -> out_err=1, out_bin=0.
- Digits 0100,0011 (last) with out_ready held low 5 cycles -> out_valid, out_bin=10 stable, in_ready=0 throughout. Release -> in_ready=1 next cycle.
- Digits 0000,0111 (last):
  - With XS3_LEGACY_ZERO_EN -> out_bin=4, out_err=0.
  - Without -> out_err=1, out_bin=0.
- Assert rst_n low after two digits of a three-digit number -> no out_valid. Next number 0101 (last) -> out_bin=2.

Source files
------------

// File: rtl/xs3_to_bin_seq.sv
// ---------------------------------------------------------------------------
// xs3_to_bin_seq
// Serial excess-3 to binary decoder. XS-3 digits arrive most-significant first
// over a valid/ready handshake. They are accumulated into a binary value. The
// value is presented with an error flag over a second valid/ready handshake.
//
// Optional feature:
//   XS3_LEGACY_ZERO_EN - when defined, code 0000 decodes as decimal 0 without
//                        error. This supports encoders that blank a leading
//                        digit. When undefined, 0000 is an illegal code.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_digit/in_last valid
//   in_ready   decoder can accept a digit (state==ACC, low during reset)
//   in_digit   XS-3 coded digit, 0011..1100 legal
//   in_last    final digit of the current number
//   out_valid  result available (state==HOLD)
//   out_ready  consumer accepts result
//   out_bin    decoded binary value (0 when out_err)
//   out_err    illegal code or digit-count overflow in this number
// ---------------------------------------------------------------------------
module xs3_to_bin_seq #(
  parameter int unsigned NDIG  = 3,
  parameter int unsigned OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_bin,
  output logic             out_err
);

  localparam int unsigned CNT_W = $clog2(NDIG + 1);
  localparam int unsigned MUL_W = OUT_W + 4;

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [OUT_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [OUT_W-1:0] out_bin_q;
  logic             out_err_q;

  logic             accept;
  logic             handshake;
  logic             code_legal;
  logic             zero_code;
  logic             ovf;
  logic [3:0]       digit_val;
  logic [OUT_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_upd;
  logic             err_upd;

  // Ready is gated by rst_n so it stays low while reset is asserted.
  assign in_ready  = rst_n & (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_bin   = out_bin_q;
  assign out_err   = out_err_q;

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  // Digit decode and accumulator update for the digit currently offered.
  always_comb begin
    code_legal = (in_digit >= 4'd3) && (in_digit <= 4'd12);
`ifdef XS3_LEGACY_ZERO_EN
    zero_code  = (in_digit == 4'd0);
`else
    zero_code  = 1'b0;
`endif
    // Illegal codes and the legacy zero both contribute 0.
    digit_val  = code_legal ? (in_digit - 4'd3) : 4'd0;
    ovf        = (cnt_q == CNT_W'(NDIG));
    // An overflowing digit leaves acc alone. cnt saturates so it cannot wrap.
    acc_upd    = ovf ? acc_q
                     : OUT_W'(MUL_W'(acc_q) * MUL_W'(10) + MUL_W'(digit_val));
    cnt_upd    = ovf ? cnt_q : (cnt_q + CNT_W'(1));
    err_upd    = err_q | ~(code_legal | zero_code) | ovf;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:  if (accept && in_last) state_d = ST_HOLD;
      ST_HOLD: if (out_ready)         state_d = ST_ACC;
      default:                        state_d = ST_ACC;
    endcase
  end

  // Accumulator, sticky error and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_bin_q <= '0;
      out_err_q <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_upd;
      cnt_q <= cnt_upd;
      err_q <= err_upd;
      if (in_last) begin
        out_bin_q <= err_upd ? '0 : acc_upd;
        out_err_q <= err_upd;
      end
    end else if (handshake) begin
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xs3_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_xs3_to_bin_seq
// Directed testbench for xs3_to_bin_seq (NDIG=3, OUT_W=10). Expected values
// are hand-computed. Inputs are driven 1 time unit after the rising edge, and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_xs3_to_bin_seq;

  localparam int unsigned NDIG  = 3;
  localparam int unsigned OUT_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_bin;
  logic             out_err;

  int n_cmp = 0;
  int n_mis = 0;

  xs3_to_bin_seq #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one digit and hold it until accepted (bounded wait).
  task automatic send_digit(input logic [3:0] dig, input logic last);
    logic seen;
    seen     = 1'b0;
    in_valid = 1'b1;
    in_digit = dig;
    in_last  = last;
    for (int n = 0; n < 20; n++) begin
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("in_ready_wait", 32'(seen), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check the presented result, then complete the output handshake.
  task automatic take_result(input string tag, input int exp_bin, input logic exp_err);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_bin"}, 32'(out_bin), 32'(exp_bin));
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
    check({tag, "_vld_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_digit  = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bin", 32'(out_bin), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    tick();

    // 4,5,6 -> 123. out_valid rises right after the last accept edge.
    send_digit(4'b0100, 1'b0);
    send_digit(4'b0101, 1'b0);
    check("pre_last_valid", 32'(out_valid), 32'd0);
    send_digit(4'b0110, 1'b1);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_in_ready", 32'(in_ready), 32'd0);
    take_result("n123", 123, 1'b0);

    // Single digit 1100 -> 9.
    send_digit(4'b1100, 1'b1);
    take_result("n9", 9, 1'b0);

    // 0011 -> 0, with out_ready already high when out_valid rises.
    out_ready = 1'b1;
    send_digit(4'b0011, 1'b1);
    check("n0_valid", 32'(out_valid), 32'd1);
    check("n0_bin", 32'(out_bin), 32'd0);
    check("n0_err", 32'(out_err), 32'd0);
    tick();
    check("n0_rdy_after", 32'(in_ready), 32'd1);
    check("n0_vld_after", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Illegal code mid-number -> error, value forced to 0.
    send_digit(4'b0100, 1'b0);
    send_digit(4'b1111, 1'b0);
    send_digit(4'b0011, 1'b1);
    take_result("illegal", 0, 1'b1);

    // Sticky error cleared for the next number.
    send_digit(4'b0110, 1'b1);
    take_result("after_err", 3, 1'b0);

    // Four digits with NDIG=3 -> count overflow.
    send_digit(4'b0100, 1'b0);
    send_digit(4'b0100, 1'b0);
    send_digit(4'b0100, 1'b0);
    send_digit(4'b0100, 1'b1);
    take_result("ovf", 0, 1'b1);

    // 1,0 -> 10 with output stalled for 5 cycles. A digit offered during
    // HOLD must not be taken until HOLD ends.
    send_digit(4'b0100, 1'b0);
    send_digit(4'b0011, 1'b1);
    in_valid = 1'b1;
    in_digit = 4'b0101;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_bin", 32'(out_bin), 32'd10);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_rel_ready", 32'(in_ready), 32'd1);
    check("stall_rel_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_result("held_digit", 2, 1'b0);

    // Code 0000 followed by 0111.
    send_digit(4'b0000, 1'b0);
    send_digit(4'b0111, 1'b1);
`ifdef XS3_LEGACY_ZERO_EN
    take_result("legacy0", 4, 1'b0);
`else
    take_result("legacy0", 0, 1'b1);
`endif

    // Reset mid-number discards the partial value.
    send_digit(4'b0100, 1'b0);
    send_digit(4'b0101, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("post_rst_valid", 32'(out_valid), 32'd0);
      tick();
    end
    send_digit(4'b0101, 1'b1);
    take_result("post_rst", 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
